graph_mem_arbiter: RTL and testbench
====================================

Name: graph_mem_arbiter

Overview:
Shares one graph_memory read port among NUM_REQ requesters, for example several graph_fetch engines or a fetch engine plus a checked/visited updater. Requests are granted round-robin, one per cycle. Each grant is forwarded to memory after a one-cycle register. Returns come back in order, and each one is routed to the requester that issued it using an in-flight ID FIFO. The block sits between the requesters' mem_req/mem_valid ports and one port (a or b) of graph_memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, request address width
DATA_W, 32, memory data width
MAX_OUTSTANDING, 8, maximum in-flight requests; also the ID FIFO depth (power of 2)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
req_valid_in  in  [NUM_REQ]  requester i has a request pending
req_addr_in  in  [NUM_REQ][ADDR_W]  requester i address
req_ready_out  out  [NUM_REQ]  combinational grant, one-hot or zero
mem_req_out  out  ADDR_W  address to graph_memory
mem_valid_out  out  1  request strobe to graph_memory
mem_data_in  in  DATA_W  read data from graph_memory
mem_valid_in  in  1  read data valid, in request order
resp_data_out  out  DATA_W  returned data, shared by all requesters
resp_valid_out  out  [NUM_REQ]  one-hot: resp_data_out belongs to requester i
outstanding_out  out  $clog2(MAX_OUTSTANDING)+1  in-flight count
busy_out  out  1  outstanding_out != 0
err_out  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: mem_valid_out=0, mem_req_out=0, resp_valid_out=0, resp_data_out=0, outstanding=0, FIFO empty, rr_ptr=0, err_out=0.
- graph_memory shares rst_in, so no pre-reset responses survive a reset. Reset asserted mid-operation discards all in-flight state in the same cycle.
- Grant logic (combinational):
  - can_issue = (outstanding < MAX_OUTSTANDING) || mem_valid_in. A same-cycle pop frees a slot.
  - When can_issue is true, scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ and assert req_ready_out on the first i with req_valid_in[i]=1.
  - A transfer happens when req_valid_in[i] & req_ready_out[i].
- Requester rules:
  - req_valid_in must stay high and req_addr_in stable until the transfer.
  - req_ready_out never depends on the requester's own ready.
- Round-robin pointer:
  - After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - Fairness guarantee: a continuously requesting requester is granted within NUM_REQ cycles, provided capacity is available.
- Issue path, latency 1:
  - On a transfer, the next cycle has mem_valid_out=1 and mem_req_out=req_addr_in[g]. Otherwise mem_valid_out=0 and mem_req_out holds.
  - The ID g is pushed into the FIFO in the transfer cycle.
- Return path, latency 1:
  - On mem_valid_in with the FIFO non-empty, the next cycle has resp_valid_out = one-hot(FIFO head) and resp_data_out = mem_data_in. The head is popped.
  - There is no backpressure; requesters must accept every response.
- Outstanding counter:
  - Increments on push and decrements on pop.
  - A simultaneous push and pop leaves it unchanged.
  - It never exceeds MAX_OUTSTANDING.
- Boundary conditions:
  - Full (outstanding = MAX_OUTSTANDING) with no mem_valid_in: req_ready_out = 0.
  - Full with mem_valid_in: one grant is allowed.
  - mem_valid_in with an empty FIFO: the data is dropped, resp_valid_out stays 0, and err_out is set sticky until rst_in.
  - FIFO pointers wrap mod MAX_OUTSTANDING. Full and empty are distinguished by an extra pointer bit.
- State machine: none beyond rr_ptr, the FIFO and the counter. The block is a pure pipelined arbiter with two 1-cycle register stages.

Decomposition:
- Shared package graph_pkg holds:
  - ADDR_W/DATA_W defaults.
  - typedef req_id_t = logic [$clog2(NUM_REQ)-1:0].
  - A function rr_pick(valid, ptr) returning the granted index and a found flag.
- One sub-module, id_fifo, a synchronous FIFO (WIDTH, DEPTH) with:
  - push, pop, head, full, empty and count.
  - Same-cycle push+pop allowed when full or empty, with the input bypassed when empty.

Test Plan:
- Single requester: req_valid_in=4'b0010, addr=0x40; mem returns 0xDEAD three cycles later → mem_valid_out at T+1 with addr 0x40; resp_valid_out=4'b0010 with data 0xDEAD at mem_valid_in+1; outstanding 1→0.
- Round-robin: all four requesters hold valid, addrs 0x10/0x20/0x30/0x40 → mem_req_out sequence 0x10,0x20,0x30,0x40,0x10 on consecutive cycles; responses are routed to IDs 0,1,2,3,0 in order.
- Full: memory stalls, 8 grants are issued → req_ready_out=0 on cycle 9. A single mem_valid_in then enables exactly one grant in that cycle, and outstanding stays 8.
- Spurious return: mem_valid_in pulsed after reset with no requests → resp_valid_out stays 0 and err_out=1 until rst_in.
- Reset mid-flight: 3 requests outstanding, then rst_in for 1 cycle → next cycle outstanding_out=0, busy_out=0, rr_ptr=0 (requester 0 granted first when all valid), mem_valid_out=0.
- Pointer skip: valid=4'b1001 with rr_ptr=1 → grant 3, then grant 0, then grant 3.

Source files
------------

// File: rtl/graph_pkg.sv
// rtl/graph_pkg.sv - shared widths, requester ID type and round-robin pick helper
package graph_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int GRAPH_MAX_REQ = 8;
  localparam int REQ_ID_W      = $clog2(GRAPH_MAX_REQ);

  // Sized for the largest supported requester count so every instance shares one ID type.
  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    found;
    req_id_t idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo num.
  function automatic rr_pick_t rr_pick(input logic [GRAPH_MAX_REQ-1:0] valid,
                                       input req_id_t ptr, input int num);
    rr_pick_t r;
    int i;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < GRAPH_MAX_REQ; k++) begin
      i = (int'(ptr) + k) % num;
      if (k < num && !r.found && valid[i[REQ_ID_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = i[REQ_ID_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/graph_mem_arbiter_id_fifo.sv
// rtl/graph_mem_arbiter_id_fifo.sv - synchronous ID FIFO with extra-bit full/empty pointers
module id_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             bypass;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? din : mem[rd_ptr[AW-1:0]];

  // A pop frees a slot for a same-cycle push; a push feeds a same-cycle pop when empty.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign bypass  = empty && do_push && do_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push && !bypass) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop && !bypass)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !bypass) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// rtl/graph_mem_arbiter.sv - round-robin arbiter sharing one graph_memory read port
// Grants one requester per cycle, registers the issue, and routes in-order returns by ID.
module graph_mem_arbiter
  import graph_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  output logic [ADDR_W-1:0]               mem_req_out,
  output logic                            mem_valid_out,
  input  logic [DATA_W-1:0]               mem_data_in,
  input  logic                            mem_valid_in,
  output logic [DATA_W-1:0]               resp_data_out,
  output logic [NUM_REQ-1:0]              resp_valid_out,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out,
  output logic                            busy_out,
  output logic                            err_out
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  req_id_t                  rr_ptr;
  req_id_t                  rr_next;
  logic [GRAPH_MAX_REQ-1:0] valid_ext;
  rr_pick_t                 pick;
  logic                     can_issue;
  logic                     grant;
  logic [ADDR_W-1:0]        grant_addr;
  logic                     pop;
  req_id_t                  fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [NUM_REQ-1:0]       resp_onehot;

  // A return in this cycle frees a slot, so a full FIFO may still accept one grant.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid_in;
    pick                     = rr_pick(valid_ext, rr_ptr, NUM_REQ);
    can_issue                = !fifo_full || mem_valid_in;
    grant                    = can_issue && pick.found;
    req_ready_out            = '0;
    grant_addr               = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && pick.idx == req_id_t'(i)) begin
        req_ready_out[i] = 1'b1;
        grant_addr       = req_addr_in[i];
      end
    end
  end

  always_comb begin
    resp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_onehot[i] = (fifo_head == req_id_t'(i));
    end
  end

  assign rr_next = (pick.idx == req_id_t'(NUM_REQ - 1)) ? '0 : pick.idx + 1'b1;

  // Returns with nothing in flight are dropped and flagged instead of popped.
  assign pop = mem_valid_in && !fifo_empty;

  id_fifo #(
    .WIDTH ($bits(req_id_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (grant),
    .pop    (pop),
    .din    (pick.idx),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr         <= '0;
      mem_valid_out  <= 1'b0;
      mem_req_out    <= '0;
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      err_out        <= 1'b0;
    end else begin
      mem_valid_out  <= grant;
      resp_valid_out <= pop ? resp_onehot : '0;
      if (grant) begin
        mem_req_out <= grant_addr;
        rr_ptr      <= rr_next;
      end
      if (pop) resp_data_out <= mem_data_in;
      if (mem_valid_in && fifo_empty) err_out <= 1'b1;
    end
  end

  assign outstanding_out = fifo_count;
  assign busy_out        = (fifo_count != '0);

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// tb/tb_graph_mem_arbiter.sv - self-checking bench for graph_mem_arbiter
module tb_graph_mem_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0]         req_ready;
  logic [AW-1:0]         mem_req;
  logic                  mem_valid_out;
  logic [DW-1:0]         mem_data;
  logic                  mem_valid_in;
  logic [DW-1:0]         resp_data;
  logic [NR-1:0]         resp_valid;
  logic [$clog2(MAXO):0] outstanding;
  logic                  busy;
  logic                  err;

  int n_cmp  = 0;
  int n_fail = 0;

  int            m_q[$];
  int            m_rr = 0;
  bit            m_live = 1'b0;
  logic          m_mv = 1'b0;
  logic [AW-1:0] m_mr = '0;
  logic [NR-1:0] m_rv = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_err = 1'b0;
  logic [NR-1:0] m_grant = '0;

  always #5 clk = ~clk;

  graph_mem_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .req_valid_in    (req_valid),
    .req_addr_in     (req_addr),
    .req_ready_out   (req_ready),
    .mem_req_out     (mem_req),
    .mem_valid_out   (mem_valid_out),
    .mem_data_in     (mem_data),
    .mem_valid_in    (mem_valid_in),
    .resp_data_out   (resp_data),
    .resp_valid_out  (resp_valid),
    .outstanding_out (outstanding),
    .busy_out        (busy),
    .err_out         (err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of in-flight IDs, scan-order grant, applied between edges.
  always @(negedge clk) begin : model
    logic [NR-1:0] eg;
    int g;
    int id;
    eg = '0;
    g  = -1;
    if ((m_q.size() < MAXO) || mem_valid_in) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    m_grant = eg;
    if (m_live) begin
      check("req_ready", req_ready, eg);
      check("mem_valid_out", mem_valid_out, m_mv);
      check("mem_req_out", mem_req, m_mr);
      check("resp_valid", resp_valid, m_rv);
      if (m_rv != '0) check("resp_data", resp_data, m_rd);
      check("outstanding", outstanding, m_q.size());
      check("busy", busy, m_q.size() != 0);
      check("err", err, m_err);
    end
    if (rst) begin
      m_q.delete();
      m_rr   = 0;
      m_mv   = 1'b0;
      m_mr   = '0;
      m_rv   = '0;
      m_rd   = '0;
      m_err  = 1'b0;
      m_live = 1'b1;
    end else begin
      m_rv = '0;
      if (mem_valid_in) begin
        if (m_q.size() > 0) begin
          id = m_q.pop_front();
          m_rv[id] = 1'b1;
          m_rd = mem_data;
        end else begin
          m_err = 1'b1;
        end
      end
      m_mv = (g >= 0);
      if (g >= 0) begin
        m_q.push_back(g);
        m_mr = req_addr[g];
        m_rr = (g + 1) % NR;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    mem_valid_in = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int k = 0; k < 40 && m_q.size() > 0; k++) begin
      mem_valid_in = 1'b1;
      mem_data     = $urandom;
      cyc();
    end
    mem_valid_in = 1'b0;
    smp();
    check("drain_outstanding", outstanding, 0);
    cyc();
  endtask

  logic [AW-1:0] exp_rr_addr[5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h10};
  logic [NR-1:0] exp_rr_resp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int            pcts[3] = '{10, 50, 90};

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_addr     = '0;
    mem_valid_in = 1'b0;
    mem_data     = '0;
    cyc();
    do_reset();
    smp();
    check("reset_mem_valid", mem_valid_out, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_err", err, 0);
    cyc();

    // single requester
    req_valid   = 4'b0010;
    req_addr[1] = 32'h40;
    smp();
    check("single_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    smp();
    check("single_mem_valid", mem_valid_out, 1);
    check("single_mem_req", mem_req, 32'h40);
    check("single_outstanding", outstanding, 1);
    cyc();
    cyc();
    mem_valid_in = 1'b1;
    mem_data     = 32'hDEAD;
    cyc();
    mem_valid_in = 1'b0;
    smp();
    check("single_resp_valid", resp_valid, 4'b0010);
    check("single_resp_data", resp_data, 32'hDEAD);
    check("single_outstanding_done", outstanding, 0);
    cyc();

    // round robin over four holders
    do_reset();
    req_valid = 4'b1111;
    req_addr  = {32'h40, 32'h30, 32'h20, 32'h10};
    smp();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 5) req_valid = '0;
      smp();
      check("rr_mem_req", mem_req, exp_rr_addr[k-1]);
    end
    for (int k = 0; k <= 5; k++) begin
      cyc();
      mem_valid_in = (k < 5);
      mem_data     = 32'h100 + k;
      smp();
      if (k > 0) check("rr_resp_route", resp_valid, exp_rr_resp[k-1]);
    end
    cyc();
    mem_valid_in = 1'b0;

    // full capacity
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      smp();
      cyc();
    end
    smp();
    check("full_ready", req_ready, 4'b0000);
    check("full_outstanding", outstanding, 8);
    cyc();
    mem_valid_in = 1'b1;
    smp();
    check("full_pop_ready", req_ready, 4'b0001);
    cyc();
    mem_valid_in = 1'b0;
    smp();
    check("full_still_8", outstanding, 8);
    check("full_ready_again", req_ready, 4'b0000);
    cyc();
    drain();

    // spurious return
    do_reset();
    mem_valid_in = 1'b1;
    mem_data     = 32'hBAD;
    cyc();
    mem_valid_in = 1'b0;
    smp();
    check("spur_resp_valid", resp_valid, 0);
    check("spur_err", err, 1);
    cyc();
    cyc();
    cyc();
    smp();
    check("spur_err_sticky", err, 1);
    cyc();
    do_reset();
    smp();
    check("spur_err_cleared", err, 0);
    cyc();

    // reset mid-flight
    req_valid = 4'b0111;
    cyc();
    cyc();
    cyc();
    req_valid = '0;
    rst       = 1'b1;
    smp();
    check("mid_outstanding_pre", outstanding, 3);
    cyc();
    rst       = 1'b0;
    req_valid = 4'b1111;
    smp();
    check("mid_outstanding", outstanding, 0);
    check("mid_busy", busy, 0);
    check("mid_mem_valid", mem_valid_out, 0);
    check("mid_ready", req_ready, 4'b0001);
    cyc();
    drain();

    // pointer skip
    do_reset();
    req_valid = 4'b0001;
    smp();
    check("skip_first", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b1001;
    smp();
    check("skip_g3", req_ready, 4'b1000);
    cyc();
    smp();
    check("skip_g0", req_ready, 4'b0001);
    cyc();
    smp();
    check("skip_g3b", req_ready, 4'b1000);
    cyc();
    drain();

    // randomized traffic with varying memory return rates
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < NR; i++) begin
          if (!req_valid[i] || m_grant[i]) begin
            req_valid[i] = ($urandom_range(0, 99) < 60);
            req_addr[i]  = $urandom;
          end
        end
        mem_valid_in = (m_q.size() > 0) && ($urandom_range(0, 99) < pcts[ph % 3]);
        mem_data     = $urandom;
        cyc();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
